// File: rtl/qoi_decode_if.sv
// rtl/qoi_decode_if.sv - CPU bus bundle for the QOI decoder peripheral
//
// Purpose: groups the 6502-style register bus signals.
// Signals:
//   cs      chip select, one-cycle strobe per access
//   we      1 = write, 0 = read
//   addr    register address (3 bits)
//   data_i  write data (CPU -> decoder)
//   data_o  read data (decoder -> CPU), combinational from addr
interface qoi_decode_if;
  logic       cs;
  logic       we;
  logic [2:0] addr;
  logic [7:0] data_i;
  logic [7:0] data_o;

  modport master (output cs, output we, output addr, output data_i, input data_o);
  modport slave  (input cs, input we, input addr, input data_i, output data_o);
endinterface

// File: rtl/qoi_decode.sv
// rtl/qoi_decode.sv - memory-mapped QOI chunk decoder with 64-entry pixel index
//
// Purpose: the CPU writes encoded QOI chunk bytes to addr0; the block rebuilds
// RGBA pixels and the CPU reads each back as R,G,B,A from addr0.
// Ports:
//   clk  system clock
//   rst  asynchronous active-low reset
//   bus  register bus (qoi_decode_if.slave)
// Register map:
//   0 W encoded byte      0 R current pixel byte (byte_idx selects R/G/B/A)
//   3 W bit7 = start      3 R {working, err, done, 0, byte_idx[1:0], w_flag, r_flag}
//   4-7 W size[29:0] LE   4-7 R count[29:0] LE; other addresses read 0
module qoi_decode #(
  parameter int IDX_ENTRIES = 64,
  parameter int MAX_RUN     = 62
) (
  input  logic         clk,
  input  logic         rst,
  qoi_decode_if.slave  bus
);

  localparam int IW    = $clog2(IDX_ENTRIES);
  localparam int RUN_W = $clog2(MAX_RUN + 1);

  typedef logic [7:0] byte_t;
  typedef struct packed {
    byte_t r;
    byte_t g;
    byte_t b;
    byte_t a;
  } pixel_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EMIT
  } state_t;

  localparam pixel_t RESET_PX = '{r: 8'h00, g: 8'h00, b: 8'h00, a: 8'hFF};

  state_t           state_q;
  logic [29:0]      size_q;
  logic [29:0]      count_q;
  logic [RUN_W-1:0] run_q;
  logic [1:0]       byte_idx_q;
  logic             err_q;
  logic             done_q;
  pixel_t           prev_q;
  pixel_t           idx_q [IDX_ENTRIES];
  byte_t            tag_q;
  byte_t            op_q [4];
  logic             have_tag_q;
  logic [1:0]       nop_q;

  logic wr0, rd0, wr_start, wr_size;
  assign wr0      = bus.cs &  bus.we & (bus.addr == 3'd0);
  assign rd0      = bus.cs & ~bus.we & (bus.addr == 3'd0);
  assign wr_start = bus.cs &  bus.we & (bus.addr == 3'd3) & bus.data_i[7];
  assign wr_size  = bus.cs &  bus.we &  bus.addr[2];

  // Number of operand bytes that follow a given tag byte.
  function automatic logic [2:0] need_ops(input byte_t tag);
    if (tag == 8'hFE)            need_ops = 3'd3;
    else if (tag == 8'hFF)       need_ops = 3'd4;
    else if (tag[7:6] == 2'b10)  need_ops = 3'd1;
    else                         need_ops = 3'd0;
  endfunction

  // Pixel reconstruction; all channel arithmetic wraps mod 256.
  pixel_t px_d;
  byte_t  dg;
  byte_t  hash_d;
  logic   is_run;

  always_comb begin
    px_d   = prev_q;
    dg     = {2'b00, tag_q[5:0]} - 8'd32;
    is_run = 1'b0;
    if (tag_q == 8'hFE) begin
      px_d = '{r: op_q[0], g: op_q[1], b: op_q[2], a: prev_q.a};
    end else if (tag_q == 8'hFF) begin
      px_d = '{r: op_q[0], g: op_q[1], b: op_q[2], a: op_q[3]};
    end else begin
      case (tag_q[7:6])
        2'b00: px_d = idx_q[tag_q[IW-1:0]];
        2'b01: begin
          px_d.r = prev_q.r + {6'd0, tag_q[5:4]} - 8'd2;
          px_d.g = prev_q.g + {6'd0, tag_q[3:2]} - 8'd2;
          px_d.b = prev_q.b + {6'd0, tag_q[1:0]} - 8'd2;
        end
        2'b10: begin
          px_d.r = prev_q.r + dg + ({4'd0, op_q[0][7:4]} - 8'd8);
          px_d.g = prev_q.g + dg;
          px_d.b = prev_q.b + dg + ({4'd0, op_q[0][3:0]} - 8'd8);
        end
        default: is_run = 1'b1;
      endcase
    end
    // Only the low 6 bits of the hash matter, so 8-bit wrapping sums suffice.
    hash_d = px_d.r * 8'd3 + px_d.g * 8'd5 + px_d.b * 8'd7 + px_d.a * 8'd11;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      size_q     <= '0;
      count_q    <= '0;
      run_q      <= '0;
      byte_idx_q <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      prev_q     <= RESET_PX;
      tag_q      <= '0;
      have_tag_q <= 1'b0;
      nop_q      <= '0;
      for (int i = 0; i < 4; i++) op_q[i] <= '0;
      for (int i = 0; i < IDX_ENTRIES; i++) idx_q[i] <= '0;
    end else begin
      // Size bytes land on this edge, so a start in the same cycle sees the old size.
      if (wr_size) begin
        case (bus.addr[1:0])
          2'd0: size_q[7:0]   <= bus.data_i;
          2'd1: size_q[15:8]  <= bus.data_i;
          2'd2: size_q[23:16] <= bus.data_i;
          default: size_q[29:24] <= bus.data_i[5:0];
        endcase
      end
      if (wr0 && state_q != S_FETCH) err_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          if (wr_start) begin
            if (size_q != '0) begin
              count_q    <= '0;
              err_q      <= 1'b0;
              done_q     <= 1'b0;
              run_q      <= '0;
              byte_idx_q <= '0;
              have_tag_q <= 1'b0;
              nop_q      <= '0;
              prev_q     <= RESET_PX;
              for (int i = 0; i < IDX_ENTRIES; i++) idx_q[i] <= '0;
              state_q    <= S_FETCH;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        S_FETCH: begin
          if (wr0) begin
            if (!have_tag_q) begin
              tag_q <= bus.data_i;
              nop_q <= '0;
              if (need_ops(bus.data_i) == 3'd0) state_q <= S_DECODE;
              else have_tag_q <= 1'b1;
            end else begin
              op_q[nop_q] <= bus.data_i;
              if ({1'b0, nop_q} + 3'd1 == need_ops(tag_q)) begin
                have_tag_q <= 1'b0;
                state_q    <= S_DECODE;
              end else begin
                nop_q <= nop_q + 2'd1;
              end
            end
          end
        end
        S_DECODE: begin
          prev_q               <= px_d;
          idx_q[hash_d[IW-1:0]] <= px_d;
          if (is_run) run_q <= tag_q[RUN_W-1:0];
          byte_idx_q           <= '0;
          state_q              <= S_EMIT;
        end
        S_EMIT: begin
          if (rd0) begin
            if (byte_idx_q == 2'd3) begin
              byte_idx_q <= '0;
              count_q    <= count_q + 30'd1;
              // Reaching the pixel total wins over any pending run repeats.
              if (count_q + 30'd1 == size_q) begin
                state_q <= S_IDLE;
                done_q  <= 1'b1;
                run_q   <= '0;
              end else if (run_q != '0) begin
                run_q <= run_q - 1'b1;
              end else begin
                state_q <= S_FETCH;
              end
            end else begin
              byte_idx_q <= byte_idx_q + 2'd1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  logic  working, w_flag, r_flag;
  logic [31:0] count_w;
  assign working = (state_q != S_IDLE);
  assign w_flag  = (state_q == S_FETCH);
  assign r_flag  = (state_q == S_EMIT);
  assign count_w = {2'b00, count_q};

  // Outside EMIT prev_q still holds the last pixel, so addr0 reads it unchanged.
  always_comb begin
    bus.data_o = 8'h00;
    case (bus.addr)
      3'd0: begin
        case (byte_idx_q)
          2'd0: bus.data_o = prev_q.r;
          2'd1: bus.data_o = prev_q.g;
          2'd2: bus.data_o = prev_q.b;
          default: bus.data_o = prev_q.a;
        endcase
      end
      3'd3: bus.data_o = {working, err_q, done_q, 1'b0, byte_idx_q, w_flag, r_flag};
      3'd4: bus.data_o = count_w[7:0];
      3'd5: bus.data_o = count_w[15:8];
      3'd6: bus.data_o = count_w[23:16];
      3'd7: bus.data_o = count_w[31:24];
      default: bus.data_o = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_qoi_decode.sv
// tb/tb_qoi_decode.sv - scoreboard testbench for qoi_decode
module tb_qoi_decode;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  qoi_decode_if bus_if ();

  qoi_decode #(.IDX_ENTRIES(64), .MAX_RUN(62)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];
  string      name_q [$];

  // Monitor: every CPU read on the bus pops one expected value.
  always @(negedge clk) begin
    if (rst && bus_if.cs && !bus_if.we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_read: addr=%0d got %02h, no expected value queued", bus_if.addr, bus_if.data_o);
      end else begin
        logic [7:0] e;
        string      n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        if (bus_if.data_o !== e) begin
          errors++;
          $display("FAIL %s: got %02h expected %02h", n, bus_if.data_o, e);
        end
      end
    end
  end

  function automatic logic [7:0] st(input logic wk, input logic er, input logic dn,
                                    input logic [1:0] bi, input logic wf, input logic rf);
    st = {wk, er, dn, 1'b0, bi, wf, rf};
  endfunction

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    bus_if.cs = 1'b1; bus_if.we = 1'b1; bus_if.addr = a; bus_if.data_i = d;
    @(posedge clk); #1;
    bus_if.cs = 1'b0; bus_if.we = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [7:0] e, input string n);
    exp_q.push_back(e);
    name_q.push_back(n);
    bus_if.cs = 1'b1; bus_if.we = 1'b0; bus_if.addr = a;
    @(posedge clk); #1;
    bus_if.cs = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic set_size(input logic [31:0] s);
    wr(3'd4, s[7:0]); wr(3'd5, s[15:8]); wr(3'd6, s[23:16]); wr(3'd7, s[31:24]);
  endtask

  task automatic start();
    wr(3'd3, 8'h80);
  endtask

  task automatic rd_px(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                       input logic [7:0] a, input string n);
    rd(3'd0, r, {n, "_r"});
    rd(3'd0, g, {n, "_g"});
    rd(3'd0, b, {n, "_b"});
    rd(3'd0, a, {n, "_a"});
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end

  initial begin
    bus_if.cs = 1'b0; bus_if.we = 1'b0; bus_if.addr = '0; bus_if.data_i = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Reset state
    rd(3'd3, 8'h00, "rst_status");
    rd(3'd0, 8'h00, "rst_px_r");
    rd(3'd4, 8'h00, "rst_count");
    rd(3'd1, 8'h00, "rst_addr1");

    // 1: single RGB pixel, exact latency to r_flag
    set_size(1);
    start();
    rd(3'd3, st(1, 0, 0, 0, 1, 0), "t1_fetch");
    wr(0, 8'hFE); wr(0, 8'h10); wr(0, 8'h20); wr(0, 8'h30);
    rd(3'd3, st(1, 0, 0, 0, 0, 0), "t1_decode");
    rd(3'd3, st(1, 0, 0, 0, 0, 1), "t1_rflag");
    rd_px(8'h10, 8'h20, 8'h30, 8'hFF, "t1_px");
    rd(3'd3, st(0, 0, 1, 0, 0, 0), "t1_done");
    rd(3'd4, 8'h01, "t1_count");

    // 2: RGB, DIFF, LUMA
    set_size(3);
    start();
    wr(0, 8'hFE); wr(0, 8'h10); wr(0, 8'h20); wr(0, 8'h30);
    idle(2);
    rd_px(8'h10, 8'h20, 8'h30, 8'hFF, "t2_rgb");
    wr(0, 8'h7F);
    idle(2);
    rd(3'd0, 8'h11, "t2_diff_r");
    rd(3'd0, 8'h21, "t2_diff_g");
    rd(3'd3, st(1, 0, 0, 2, 0, 1), "t2_byteidx");
    rd(3'd0, 8'h31, "t2_diff_b");
    rd(3'd0, 8'hFF, "t2_diff_a");
    wr(0, 8'hA2); wr(0, 8'h97);
    idle(2);
    rd_px(8'h14, 8'h23, 8'h32, 8'hFF, "t2_luma");
    rd(3'd3, st(0, 0, 1, 0, 0, 0), "t2_done");
    rd(3'd4, 8'h03, "t2_count");

    // 3: RGBA then INDEX lookup of hash 21
    set_size(3);
    start();
    wr(0, 8'hFE); wr(0, 8'h10); wr(0, 8'h20); wr(0, 8'h30);
    idle(2);
    rd_px(8'h10, 8'h20, 8'h30, 8'hFF, "t3_rgb");
    wr(0, 8'hFF); wr(0, 8'h00); wr(0, 8'h00); wr(0, 8'h00); wr(0, 8'hFF);
    idle(2);
    rd_px(8'h00, 8'h00, 8'h00, 8'hFF, "t3_rgba");
    wr(0, 8'h15);
    idle(2);
    rd_px(8'h10, 8'h20, 8'h30, 8'hFF, "t3_index");
    rd(3'd4, 8'h03, "t3_count");

    // 4: RUN of 3 total repeats, no fetch between run pixels
    set_size(4);
    start();
    wr(0, 8'hFE); wr(0, 8'h01); wr(0, 8'h02); wr(0, 8'h03);
    idle(2);
    rd_px(8'h01, 8'h02, 8'h03, 8'hFF, "t4_p1");
    wr(0, 8'hC2);
    idle(2);
    rd_px(8'h01, 8'h02, 8'h03, 8'hFF, "t4_p2");
    rd(3'd3, st(1, 0, 0, 0, 0, 1), "t4_run_st2");
    rd_px(8'h01, 8'h02, 8'h03, 8'hFF, "t4_p3");
    rd(3'd3, st(1, 0, 0, 0, 0, 1), "t4_run_st3");
    rd_px(8'h01, 8'h02, 8'h03, 8'hFF, "t4_p4");
    rd(3'd3, st(0, 0, 1, 0, 0, 0), "t4_done");
    rd(3'd4, 8'h04, "t4_count");

    // 5: run truncated by size, then stray write sets err, start clears it
    set_size(2);
    start();
    wr(0, 8'hFE); wr(0, 8'h05); wr(0, 8'h06); wr(0, 8'h07);
    idle(2);
    rd_px(8'h05, 8'h06, 8'h07, 8'hFF, "t5_p1");
    wr(0, 8'hC9);
    idle(2);
    rd_px(8'h05, 8'h06, 8'h07, 8'hFF, "t5_p2");
    rd(3'd3, st(0, 0, 1, 0, 0, 0), "t5_done");
    rd(3'd4, 8'h02, "t5_count");
    wr(0, 8'h00);
    rd(3'd3, st(0, 1, 1, 0, 0, 0), "t5_err");
    rd(3'd0, 8'h05, "t5_idle_rd");
    rd(3'd3, st(0, 1, 1, 0, 0, 0), "t5_idle_rd_nochg");
    start();
    rd(3'd3, st(1, 0, 0, 0, 1, 0), "t5_restart");

    // 6: reset in the middle of reading a pixel
    wr(0, 8'hFE); wr(0, 8'h0A); wr(0, 8'h0B); wr(0, 8'h0C);
    idle(2);
    rd(3'd0, 8'h0A, "t6_r");
    rd(3'd0, 8'h0B, "t6_g");
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    rd(3'd3, 8'h00, "t6_rst_status");
    rd(3'd0, 8'h00, "t6_rst_px_r");
    rd(3'd4, 8'h00, "t6_rst_count");
    set_size(0);
    start();
    rd(3'd3, st(0, 0, 1, 0, 0, 0), "t6_size0_done");
    set_size(1);
    start();
    wr(0, 8'h05);
    idle(2);
    rd_px(8'h00, 8'h00, 8'h00, 8'h00, "t6_idx_zero");
    rd(3'd3, st(0, 0, 1, 0, 0, 0), "t6_done");

    idle(2);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
